spi_fifo_bridge: RTL

- CPU-facing memory-mapped front end for the SPI core.
- Buffers CPU words in a TX FIFO and launches them into the core via its transmit_ready / data_to_transmit / data_transmit_valid handshake.
- Captures words from the core's data_in / data_in_valid into an RX FIFO for CPU reads.
- Sits between the CPU load/store path and the SPI core, one per SPI core instance.

---
 rtl/spi_fifo_bridge.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/spi_fifo_bridge.sv
// CPU-facing register front end for one SPI core: TX FIFO feeding the core's launch
// handshake, RX FIFO capturing received words, status/control registers and a level irq.
module spi_fifo_bridge #(
  parameter int W_Data     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int W_Ptr      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cpu_addr,
  input  logic              cpu_wr_en,
  input  logic              cpu_rd_en,
  input  logic [W_Data-1:0] cpu_wdata,
  output logic [W_Data-1:0] cpu_rdata,
  output logic              irq,
  input  logic              spi_transmit_ready,
  output logic [W_Data-1:0] spi_data_to_transmit,
  output logic              spi_data_transmit_valid,
  input  logic [W_Data-1:0] spi_data_in,
  input  logic              spi_data_in_valid
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [W_Ptr:0] FULL_CNT = (W_Ptr+1)'(FIFO_DEPTH);

  logic [W_Data-1:0] tx_mem [FIFO_DEPTH];
  logic [W_Data-1:0] rx_mem [FIFO_DEPTH];
  logic [W_Ptr-1:0]  tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [W_Ptr:0]    tx_cnt_q, rx_cnt_q;
  logic              tx_ovf_q, rx_ovf_q, enable_q, irq_en_q, rx_valid_prev_q, irq_q;
  logic [W_Data-1:0] rdata_q, rdata_d, tx_data_q, tx_data_d;
  state_t            state_q, state_d;
  logic [1:0]        tmo_q, tmo_d;

  logic tx_empty, tx_full, rx_empty, rx_full, busy;
  logic wr_tx, wr_ctrl, rd_rx, clr_ovf;
  logic tx_pop, tx_push, tx_drop, rx_capture, rx_pop, rx_push, rx_drop;
  logic [W_Data-1:0] status, ctrl_rd;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign busy     = (state_q != IDLE) || !tx_empty;

  assign wr_tx   = cpu_wr_en && (cpu_addr == 2'd0);
  assign wr_ctrl = cpu_wr_en && (cpu_addr == 2'd3);
  assign rd_rx   = cpu_rd_en && (cpu_addr == 2'd1);
  assign clr_ovf = wr_ctrl && cpu_wdata[2];

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign tx_pop     = (state_q == LAUNCH) && !tx_empty;
  assign tx_push    = wr_tx && (!tx_full || tx_pop);
  assign tx_drop    = wr_tx && tx_full && !tx_pop;
  assign rx_capture = spi_data_in_valid && !rx_valid_prev_q;
  assign rx_pop     = rd_rx && !rx_empty;
  assign rx_push    = rx_capture && (!rx_full || rx_pop);
  assign rx_drop    = rx_capture && rx_full && !rx_pop;

  assign status  = {{(W_Data-7){1'b0}}, tx_full, busy, rx_ovf_q, tx_ovf_q, rx_full, rx_empty, tx_empty};
  assign ctrl_rd = {{(W_Data-2){1'b0}}, irq_en_q, enable_q};

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= cpu_wdata;
    if (rx_push) rx_mem[rx_wptr_q] <= spi_data_in;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (cpu_rd_en) begin
      case (cpu_addr)
        2'd1:    rdata_d = rx_empty ? '0 : rx_mem[rx_rptr_q];
        2'd2:    rdata_d = status;
        2'd3:    rdata_d = ctrl_rd;
        default: rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: begin
        if (enable_q && !tx_empty && spi_transmit_ready) begin
          state_d   = LAUNCH;
          tx_data_d = tx_mem[tx_rptr_q];
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
        tmo_d   = '0;
      end
      WAIT_BUSY: begin
        // A core that never drops ready is assumed to have taken the word.
        if (!spi_transmit_ready)  state_d = WAIT_DONE;
        else if (tmo_q == 2'd3)   state_d = IDLE;
        else                      tmo_d   = tmo_q + 2'd1;
      end
      WAIT_DONE: begin
        if (spi_transmit_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr_q       <= '0;
      tx_rptr_q       <= '0;
      tx_cnt_q        <= '0;
      rx_wptr_q       <= '0;
      rx_rptr_q       <= '0;
      rx_cnt_q        <= '0;
      tx_ovf_q        <= 1'b0;
      rx_ovf_q        <= 1'b0;
      enable_q        <= 1'b0;
      irq_en_q        <= 1'b0;
      rx_valid_prev_q <= 1'b0;
      irq_q           <= 1'b0;
      rdata_q         <= '0;
      tx_data_q       <= '0;
      state_q         <= IDLE;
      tmo_q           <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + W_Ptr'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + W_Ptr'(1);
      tx_cnt_q <= tx_cnt_q + (W_Ptr+1)'(tx_push) - (W_Ptr+1)'(tx_pop);
      if (rx_push) rx_wptr_q <= rx_wptr_q + W_Ptr'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + W_Ptr'(1);
      rx_cnt_q <= rx_cnt_q + (W_Ptr+1)'(rx_push) - (W_Ptr+1)'(rx_pop);
      if (tx_drop)      tx_ovf_q <= 1'b1;
      else if (clr_ovf) tx_ovf_q <= 1'b0;
      if (rx_drop)      rx_ovf_q <= 1'b1;
      else if (clr_ovf) rx_ovf_q <= 1'b0;
      if (wr_ctrl) begin
        enable_q <= cpu_wdata[0];
        irq_en_q <= cpu_wdata[1];
      end
      rx_valid_prev_q <= spi_data_in_valid;
      irq_q           <= irq_en_q && (!rx_empty || tx_ovf_q || rx_ovf_q);
      rdata_q         <= rdata_d;
      tx_data_q       <= tx_data_d;
      state_q         <= state_d;
      tmo_q           <= tmo_d;
    end
  end

  assign cpu_rdata               = rdata_q;
  assign irq                     = irq_q;
  assign spi_data_to_transmit    = tx_data_q;
  assign spi_data_transmit_valid = (state_q == LAUNCH);

endmodule
